sort_ctrl: RTL

- Stream-side controller for the systolic sort core: buffers a block of SIZE words from an upstream valid/ready stream and resets the core.
- Feeds the words to the core on its two-cycle-per-word intake schedule, then captures the core's serial output.
- Replays the sorted block downstream on a valid/ready stream with a last marker.
- Sits between the bus-side stream fabric and one sort core instance; it owns the core's reset.

---
 rtl/sort_ctrl_if.sv | 16 +
 rtl/sort_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/sort_ctrl_if.sv
// Word streams around the sort controller: block intake upstream and
// sorted replay downstream, both valid/ready.
interface sort_ctrl_if #(parameter int WIDTH = 32);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;

   modport slave  (input  in_data, in_valid, out_ready,
                   output in_ready, out_data, out_valid, out_last);
   modport master (output in_data, in_valid, out_ready,
                   input  in_ready, out_data, out_valid, out_last);
endinterface

// File: rtl/sort_ctrl.sv
// Buffers one block, resets and feeds the systolic sort core on its
// two-cycle intake schedule, collects the serial result and replays it.
module sort_ctrl #(
   parameter int SIZE    = 8,
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 8*SIZE+16
) (
   input  logic             clk,
   input  logic             rst_n,
   sort_ctrl_if.slave       st,
   output logic             core_rst_n,
   output logic [WIDTH-1:0] core_d,
   input  logic [WIDTH-1:0] core_q,
   input  logic             core_active_input,
   input  logic             core_active_output,
   output logic             busy,
   output logic             err
);
   localparam int CW = $clog2(SIZE+1);
   localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam int TW = $clog2(TIMEOUT+1);
   localparam logic [CW-1:0] LAST  = CW'(SIZE-1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT-1);

   typedef enum logic [2:0] {FILL, KICK, FEED, WAIT_OUT, COLLECT, DRAIN} state_t;
   state_t state, state_d;

   logic [SIZE-1:0][WIDTH-1:0] mem;
   logic [CW-1:0] wcnt, rcnt, ocnt, fidx;
   logic [TW-1:0] tcnt;
   logic          ph, started;
   logic          in_acc, out_acc, res_wr, tmo, err_c;

   always_comb begin
      state_d = state;
      err_c   = 1'b0;
      in_acc  = (state == FILL) && st.in_valid;
      out_acc = (state == DRAIN) && st.out_ready;
      res_wr  = ((state == WAIT_OUT) || (state == COLLECT)) && core_active_output;
      tmo     = ((state == FEED) || (state == WAIT_OUT)) && (tcnt == TLAST);
      case (state)
         FILL:     if (in_acc && (wcnt == LAST)) state_d = KICK;
         KICK:     state_d = FEED;
         FEED: begin
            if (tmo) begin
               err_c   = 1'b1;
               state_d = FILL;
            end else if (started && ph && (fidx == LAST)) begin
               state_d = WAIT_OUT;
            end
         end
         // a result arriving on the timeout cycle still counts as in time
         WAIT_OUT: begin
            if (core_active_output) begin
               state_d = (SIZE == 1) ? DRAIN : COLLECT;
            end else if (tmo) begin
               err_c   = 1'b1;
               state_d = FILL;
            end
         end
         COLLECT: begin
            if (!core_active_output) begin
               err_c   = 1'b1;
               state_d = FILL;
            end else if (rcnt == LAST) begin
               state_d = DRAIN;
            end
         end
         DRAIN:    if (out_acc && (ocnt == LAST)) state_d = FILL;
         default:  state_d = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= FILL;
         wcnt    <= '0;
         rcnt    <= '0;
         ocnt    <= '0;
         fidx    <= '0;
         tcnt    <= '0;
         ph      <= 1'b0;
         started <= 1'b0;
      end else begin
         state <= state_d;
         case (state)
            FILL: if (in_acc) wcnt <= wcnt + 1'b1;
            // every block starts from clean counters here
            KICK: begin
               wcnt    <= '0;
               rcnt    <= '0;
               ocnt    <= '0;
               fidx    <= '0;
               tcnt    <= '0;
               ph      <= 1'b0;
               started <= 1'b0;
            end
            FEED: begin
               tcnt <= tcnt + 1'b1;
               if (!started) begin
                  started <= core_active_input;
               end else begin
                  ph <= ~ph;
                  if (ph) fidx <= fidx + 1'b1;
               end
            end
            WAIT_OUT: begin
               tcnt <= tcnt + 1'b1;
               if (res_wr) rcnt <= rcnt + 1'b1;
            end
            COLLECT: if (res_wr) rcnt <= rcnt + 1'b1;
            DRAIN:   if (out_acc) ocnt <= ocnt + 1'b1;
            default: ;
         endcase
      end
   end

   // one buffer serves both the raw block and the sorted result
   always_ff @(posedge clk) begin
      if (in_acc)      mem[wcnt[IW-1:0]] <= st.in_data;
      else if (res_wr) mem[rcnt[IW-1:0]] <= core_q;
   end

   assign st.in_ready  = rst_n && (state == FILL);
   assign st.out_valid = rst_n && (state == DRAIN);
   assign st.out_data  = st.out_valid ? mem[ocnt[IW-1:0]] : '0;
   assign st.out_last  = st.out_valid && (ocnt == LAST);
   assign core_rst_n   = rst_n && (state != KICK);
   assign core_d       = (rst_n && (state == FEED) && started) ? mem[fidx[IW-1:0]] : '0;
   assign busy         = rst_n && (state != FILL);
   assign err          = rst_n && err_c;
endmodule
